// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared state encoding and read-admission helper for the burst reader
package fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   // A new read may issue only if the word it returns will have a slot in the
   // 2-entry output buffer: buffered words plus the word already in flight,
   // minus the word leaving this cycle, must stay below two.
   function automatic logic room_for_read(input logic [1:0] occ,
                                          input logic       inflight,
                                          input logic       pop);
      logic [2:0] pending;
      pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      return pending < 3'd2;
   endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - control, upstream FIFO and output stream signals of the burst reader
interface fifo_burst_reader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_W      = 8
);
   logic                  start;
   logic [LEN_W-1:0]      len;
   logic                  busy;
   logic                  done;
   logic                  fifo_rd_en;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;

   // Reader side: consumes commands and FIFO data, produces the stream.
   modport master (
      input  start, len, fifo_empty, fifo_data, m_ready,
      output busy, done, fifo_rd_en, m_valid, m_data, m_last
   );

   // Environment side: issues commands, models the FIFO, sinks the stream.
   modport slave (
      output start, len, fifo_empty, fifo_data, m_ready,
      input  busy, done, fifo_rd_en, m_valid, m_data, m_last
   );
endinterface

// File: rtl/fifo_skid2.sv
// rtl/fifo_skid2.sv - two-entry ordered output buffer with valid/ready and occupancy
module fifo_skid2 #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            occ
);
   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] tail_q;
   logic                  pop;

   assign out_valid = (occ != 2'd0);
   assign pop       = out_valid && out_ready;
   assign out_data  = head_q;

   // Head always holds the oldest word; tail backs it up when two are buffered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ    <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case ({in_valid, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  head_q <= in_data;
                  occ    <= 2'd1;
               end else if (occ == 2'd1) begin
                  tail_q <= in_data;
                  occ    <= 2'd2;
               end
            end
            2'b01: begin
               head_q <= tail_q;
               occ    <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  head_q <= in_data;
               end else begin
                  head_q <= tail_q;
                  tail_q <= in_data;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - reads a counted burst from a FIFO and replays it as a stream
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_W      = 8
) (
   input logic                 clk,
   input logic                 rst,
   fifo_burst_reader_if.master bus
);
   import fifo_pkg::*;

   rd_state_t             state;
   logic [LEN_W-1:0]      issue_rem;
   logic [LEN_W-1:0]      send_rem;
   logic                  inflight;
   logic                  done_q;
   logic [1:0]            occ;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  pop;
   logic                  rd_en;

   assign pop   = out_valid && bus.m_ready;
   assign rd_en = (state == RUN) && (issue_rem != '0) && !bus.fifo_empty
                  && room_for_read(occ, inflight, pop);

   // The FIFO returns data one cycle after the read, so inflight doubles as the push strobe.
   fifo_skid2 #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inflight),
      .in_data   (bus.fifo_data),
      .out_valid (out_valid),
      .out_ready (bus.m_ready),
      .out_data  (out_data),
      .occ       (occ)
   );

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = out_valid;
   assign bus.m_data     = out_data;
   assign bus.m_last     = out_valid && (send_rem == LEN_W'(1));
   assign bus.busy       = (state != IDLE);
   assign bus.done       = done_q;

   // Burst sequencing: count reads issued and words delivered, pulse done at the end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         issue_rem <= '0;
         send_rem  <= '0;
         inflight  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         inflight <= rd_en;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.len != '0) begin
                     state     <= RUN;
                     issue_rem <= bus.len;
                     send_rem  <= bus.len;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (rd_en) begin
                  issue_rem <= issue_rem - LEN_W'(1);
                  if (issue_rem == LEN_W'(1)) state <= DRAIN;
               end
               if (pop && send_rem != '0) send_rem <= send_rem - LEN_W'(1);
            end
            DRAIN: begin
               if (pop && send_rem != '0) begin
                  send_rem <= send_rem - LEN_W'(1);
                  if (send_rem == LEN_W'(1)) begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - scoreboard bench for the FIFO burst reader
`timescale 1ns/1ps
module tb_fifo_burst_reader;
   localparam int DW = 8;
   localparam int LW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_burst_reader_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();

   fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic [DW-1:0] fq[$];
   logic [DW:0]   exp_q[$];
   logic [DW-1:0] rd_word;
   logic [DW:0]   e;

   int first_rd, first_vld, first_hs, last_hs, done_cyc;
   int done_cnt, hs_cnt, rd_cnt, busy_cnt;
   int rd_total = 0;
   int hs_total = 0;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] stall_data;
   logic          stall_last;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      first_rd = -1; first_vld = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
      done_cnt = 0; hs_cnt = 0; rd_cnt = 0; busy_cnt = 0;
   endtask

   // Upstream FIFO model: registered read data and registered empty flag
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         bus.fifo_data <= '0;
      end else if (bus.fifo_rd_en && fq.size() > 0) begin
         rd_word = fq.pop_front();
         bus.fifo_data <= rd_word;
      end
      bus.fifo_empty <= (fq.size() == 0);
   end

   // Monitor: scoreboard compare, hold checks, read-admission checks, event timing
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.fifo_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            check("rd_en_room",
                  longint'((rd_total - hs_total - ((bus.m_valid && bus.m_ready) ? 1 : 0)) < 2), 1);
            check("rd_en_nonempty", longint'(bus.fifo_empty), 0);
         end
         if (stall_prev) begin
            check("hold_valid", longint'(bus.m_valid), 1);
            check("hold_data", longint'(bus.m_data), longint'(stall_data));
            check("hold_last", longint'(bus.m_last), longint'(stall_last));
         end
         if (bus.m_valid && first_vld < 0) first_vld = cyc;
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_word: got 'h%0h expected none", bus.m_data);
            end else begin
               e = exp_q.pop_front();
               check("word_data", longint'(bus.m_data), longint'(e[DW-1:0]));
               check("word_last", longint'(bus.m_last), longint'(e[DW]));
            end
            hs_cnt++;
            hs_total++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
         end
         if (bus.fifo_rd_en) rd_total++;
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (bus.busy) busy_cnt++;
         stall_prev = bus.m_valid && !bus.m_ready;
         stall_data = bus.m_data;
         stall_last = bus.m_last;
      end
   end

   task automatic start_burst(input int n, output int t);
      clear_stats();
      bus.len   = LW'(n);
      bus.start = 1'b1;
      t         = cyc + 1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_seen", longint'(done_cnt > 0), 1);
   endtask

   task automatic load(input logic [DW-1:0] first, input int n, input int n_exp);
      logic [DW-1:0] w;
      w = first;
      for (int i = 0; i < n; i++) begin
         fq.push_back(w);
         if (i < n_exp) exp_q.push_back({(i == n_exp - 1), w});
         w = w + 1'b1;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, longint'(bus.busy), 0);
      check({tag, "_done"}, longint'(bus.done), 0);
      check({tag, "_rd_en"}, longint'(bus.fifo_rd_en), 0);
      check({tag, "_m_valid"}, longint'(bus.m_valid), 0);
      check({tag, "_m_last"}, longint'(bus.m_last), 0);
      check({tag, "_m_data"}, longint'(bus.m_data), 0);
   endtask

   initial begin
      int t;
      int n;
      logic [3:0] pat;
      clear_stats();
      bus.start   = 1'b0;
      bus.len     = '0;
      bus.m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Full-rate burst of four preloaded words
      bus.m_ready = 1'b1;
      load(8'h11, 4, 4);
      repeat (2) @(posedge clk); #1;
      start_burst(4, t);
      wait_done(40);
      check("t1_first_rd", longint'(first_rd - t), 0);
      check("t1_first_valid", longint'(first_vld - t), 2);
      check("t1_words", longint'(hs_cnt), 4);
      check("t1_back_to_back", longint'(last_hs - first_hs), 3);
      check("t1_done_lat", longint'(done_cyc - last_hs), 1);
      check("t1_exp_left", longint'(exp_q.size()), 0);

      // Backpressure pattern 1,0,0,1
      load(8'h21, 3, 3);
      repeat (2) @(posedge clk); #1;
      start_burst(3, t);
      pat = 4'b1001;
      n = 0;
      while (done_cnt == 0 && n < 60) begin
         bus.m_ready = pat[n % 4];
         @(posedge clk); #1;
         n++;
      end
      check("t2_done_seen", longint'(done_cnt), 1);
      check("t2_words", longint'(hs_cnt), 3);
      check("t2_exp_left", longint'(exp_q.size()), 0);
      bus.m_ready = 1'b1;

      // FIFO runs dry mid-burst, refilled ten cycles later
      load(8'h31, 2, 5);
      exp_q.push_back({1'b0, 8'h33});
      exp_q.push_back({1'b0, 8'h34});
      exp_q.push_back({1'b1, 8'h35});
      repeat (2) @(posedge clk); #1;
      start_burst(5, t);
      n = 0;
      while (done_cnt == 0 && n < 60) begin
         if (n == 10) begin
            check("t3_reads_stalled", longint'(rd_cnt), 2);
            fq.push_back(8'h33);
            fq.push_back(8'h34);
            fq.push_back(8'h35);
         end
         @(posedge clk); #1;
         n++;
      end
      check("t3_done_seen", longint'(done_cnt), 1);
      check("t3_words", longint'(hs_cnt), 5);
      check("t3_busy_throughout", longint'(busy_cnt), longint'(done_cyc - t));
      check("t3_exp_left", longint'(exp_q.size()), 0);

      // Zero-length request
      start_burst(0, t);
      repeat (4) @(posedge clk); #1;
      check("t4_done_lat", longint'(done_cyc - t), 0);
      check("t4_done_count", longint'(done_cnt), 1);
      check("t4_no_reads", longint'(rd_cnt), 0);
      check("t4_never_busy", longint'(busy_cnt), 0);

      // Second start while busy is ignored
      load(8'h51, 5, 3);
      repeat (2) @(posedge clk); #1;
      start_burst(3, t);
      bus.len   = LW'(5);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(40);
      repeat (5) @(posedge clk); #1;
      check("t5_words", longint'(hs_cnt), 3);
      check("t5_done_count", longint'(done_cnt), 1);
      check("t5_fifo_left", longint'(fq.size()), 2);
      check("t5_exp_left", longint'(exp_q.size()), 0);
      fq.delete();
      repeat (2) @(posedge clk); #1;

      // Reset in the middle of a six-word burst, then a one-word burst
      load(8'h61, 6, 6);
      repeat (2) @(posedge clk); #1;
      start_burst(6, t);
      n = 0;
      while (hs_cnt < 2 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("t6_two_words", longint'(hs_cnt), 2);
      #2;
      rst = 1'b1;
      #1;
      check_outputs_zero("t6_async");
      exp_q.delete();
      fq.delete();
      rd_total   = 0;
      hs_total   = 0;
      stall_prev = 1'b0;
      repeat (2) @(posedge clk); #1;
      check_outputs_zero("t6_held");
      rst = 1'b0;
      @(posedge clk); #1;
      load(8'h77, 1, 1);
      repeat (2) @(posedge clk); #1;
      start_burst(1, t);
      wait_done(40);
      check("t6_words", longint'(hs_cnt), 1);
      check("t6_exp_left", longint'(exp_q.size()), 0);
      check("t6_idle_after", longint'(bus.busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
